// File: rtl/svm_reduce_ctrl.sv
// -----------------------------------------------------------------------------
// svm_reduce_ctrl
//
// Collects NUM_IN signed operands into a buffer, then reduces them in place
// with a 3-input adder tree executed over successive passes (each pass folds
// the live entries by three until one value remains), and presents the sum
// on a valid/ready output.
//
// Optional feature (macro SVM_REDUCE_BIAS_EN): adds a signed bias input that is
// sampled on the final LOAD beat and added to the reduced sum.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bias       [ACC_W] signed bias (only with SVM_REDUCE_BIAS_EN)
//   in_data    [IN_W] signed operand
//   in_valid   operand present
//   in_ready   operand accepted this cycle (LOAD state)
//   out_data   [ACC_W] signed reduced sum, held stable while out_valid
//   out_valid  result present (DONE state)
//   out_ready  consumer takes the result
//   busy       high while reducing or holding a result
// -----------------------------------------------------------------------------
module svm_reduce_ctrl #(
    parameter int NUM_IN = 27,
    parameter int IN_W   = 18,
    parameter int ACC_W  = 24
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SVM_REDUCE_BIAS_EN
    input  logic [ACC_W-1:0] bias,
`endif
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    // Counter width leaves headroom for rd+3 and cnt+2 without wrapping; the
    // buffer is sized to the full index range so every read index is legal.
    localparam int CW    = $clog2(NUM_IN + 3);
    localparam int DEPTH = 2 ** CW;

    typedef enum logic [1:0] {
        S_LOAD,
        S_REDUCE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    wr_q, wr_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [ACC_W-1:0] bias_q, bias_d;

    logic [ACC_W-1:0] buf_mem [DEPTH];
    logic             wr_en;
    logic [CW-1:0]    wr_idx;
    logic [ACC_W-1:0] wr_val;

    logic [CW-1:0]    rd1, rd2, cnt_fold;
    logic [ACC_W-1:0] op0, op1, op2, sum3;
    logic             pass_end;

    assign rd1      = rd_q + CW'(1);
    assign rd2      = rd_q + CW'(2);
    assign cnt_fold = (cnt_q + CW'(2)) / CW'(3);   // ceil(cnt/3)
    assign pass_end = (rd_q + CW'(3)) >= cnt_q;

    // Entries at or beyond the live count are stale from earlier passes, so
    // the partial triplet at the end of a pass is padded with zero.
    assign op0  = (rd_q < cnt_q) ? buf_mem[rd_q] : '0;
    assign op1  = (rd1  < cnt_q) ? buf_mem[rd1]  : '0;
    assign op2  = (rd2  < cnt_q) ? buf_mem[rd2]  : '0;
    assign sum3 = op0 + op1 + op2;

`ifdef SVM_REDUCE_BIAS_EN
    logic [ACC_W-1:0] bias_in;
    assign bias_in = bias;
`else
    logic [ACC_W-1:0] bias_in;
    assign bias_in = '0;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        out_data_d = out_data_q;
        bias_d     = bias_q;
        wr_en      = 1'b0;
        wr_idx     = wr_q;
        wr_val     = sum3;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_idx   = ld_cnt_q;
                    wr_val   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
                    ld_cnt_d = ld_cnt_q + CW'(1);
                    if (ld_cnt_q == CW'(NUM_IN - 1)) begin
                        state_d  = S_REDUCE;
                        ld_cnt_d = '0;
                        cnt_d    = CW'(NUM_IN);
                        rd_d     = '0;
                        wr_d     = '0;
                        bias_d   = bias_in;
                    end
                end
            end
            S_REDUCE: begin
                busy   = 1'b1;
                wr_en  = 1'b1;
                wr_idx = wr_q;
                wr_val = sum3;
                rd_d   = rd_q + CW'(3);
                wr_d   = wr_q + CW'(1);
                if (pass_end) begin
                    cnt_d = cnt_fold;
                    rd_d  = '0;
                    wr_d  = '0;
                    // A single remaining triplet means this sum is the result.
                    if (cnt_fold == CW'(1)) begin
                        out_data_d = sum3 + bias_q;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d  = S_LOAD;
                    ld_cnt_d = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            ld_cnt_q   <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            out_data_q <= '0;
            bias_q     <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            out_data_q <= out_data_d;
            bias_q     <= bias_d;
        end
    end

    // NOTE: the operand buffer has no reset; it is always written before it
    // is read, and leaving it unreset lets it map onto plain RAM/flops.
    // In-place reduction is safe because wr never overtakes rd: the operands
    // are read combinationally before this edge commits the sum.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_idx] <= wr_val;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_svm_reduce_ctrl.sv
// -----------------------------------------------------------------------------
// tb_svm_reduce_ctrl
//
// Self-checking bench for svm_reduce_ctrl. Two instances (NUM_IN=27 and
// NUM_IN=5) share the stimulus wires; sel5 steers the handshake to one of them.
// Expected sums come from a table of hand-computed results and from a
// reference model that simply adds the operands; expected latency comes from
// summing ceil(cnt/3) over the folding passes.
// -----------------------------------------------------------------------------
module tb_svm_reduce_ctrl;

    localparam int IN_W  = 18;
    localparam int ACC_W = 24;
`ifdef SVM_REDUCE_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             out_ready;
    logic [ACC_W-1:0] bias_in;
    logic             sel5;

    logic             iv27, iv5, ir27, ir5, ov27, ov5, busy27, busy5;
    logic [ACC_W-1:0] od27, od5;

    logic                    in_ready_m, out_valid_m, busy_m;
    logic signed [ACC_W-1:0] out_data_m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign iv27        = in_valid & ~sel5;
    assign iv5         = in_valid &  sel5;
    assign in_ready_m  = sel5 ? ir5  : ir27;
    assign out_valid_m = sel5 ? ov5  : ov27;
    assign busy_m      = sel5 ? busy5 : busy27;
    assign out_data_m  = sel5 ? od5  : od27;

    svm_reduce_ctrl #(.NUM_IN(27), .IN_W(IN_W), .ACC_W(ACC_W)) u_dut27 (
        .clk       (clk),
        .rst       (rst),
`ifdef SVM_REDUCE_BIAS_EN
        .bias      (bias_in),
`endif
        .in_data   (in_data),
        .in_valid  (iv27),
        .in_ready  (ir27),
        .out_data  (od27),
        .out_valid (ov27),
        .out_ready (out_ready),
        .busy      (busy27)
    );

    svm_reduce_ctrl #(.NUM_IN(5), .IN_W(IN_W), .ACC_W(ACC_W)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
`ifdef SVM_REDUCE_BIAS_EN
        .bias      (bias_in),
`endif
        .in_data   (in_data),
        .in_valid  (iv5),
        .in_ready  (ir5),
        .out_data  (od5),
        .out_valid (ov5),
        .out_ready (out_ready),
        .busy      (busy5)
    );

    typedef struct {
        bit s5;
        int n;
        int pat;
        int bias;
        int exp_sum;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int op_of(input int pat, input int i);
        case (pat)
            0:       return 1;
            1:       return (i % 2 == 0) ? -131072 : 131071;
            2:       return i + 1;
            3:       return -1;
            4:       return 2;
            5:       return 131071;
            6:       return -131072;
            default: return 3;
        endcase
    endfunction

    // Cycles spent reducing: each pass takes ceil(c/3) cycles and leaves
    // ceil(c/3) values, until one value remains.
    function automatic int lat_model(input int n);
        int c = n;
        int t = 0;
        while (c > 1) begin
            t += (c + 2) / 3;
            c  = (c + 2) / 3;
        end
        return t;
    endfunction

    function automatic int trunc_acc(input longint s);
        logic signed [ACC_W-1:0] t;
        t = ACC_W'(s);
        return int'(t);
    endfunction

    // Called at a negedge; returns at the negedge following the accepted beat.
    task automatic drive_beat(input int d);
        int waits = 0;
        in_data  = IN_W'(d);
        in_valid = 1'b1;
        while (!in_ready_m && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready_m) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_vector(input string tag, input bit s5, input int n,
                              input int ops[27], input int bias_v,
                              input int exp_out);
        int lat = 0;
        sel5    = s5;
        bias_in = ACC_W'(bias_v);
        for (int i = 0; i < n; i++) drive_beat(ops[i]);
        // Bias must have been captured on the final beat; disturb it now.
        bias_in = ACC_W'(bias_v + 1234);
        check({tag, "_busy"}, int'(busy_m), 1);
        check({tag, "_in_ready_low"}, int'(in_ready_m), 0);
        while (!out_valid_m && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, lat_model(n));
        check({tag, "_out_data"}, int'(out_data_m), exp_out);
        @(negedge clk);
        check({tag, "_valid_1cyc"}, int'(out_valid_m), 0);
    endtask

    initial begin
        int ops[27];
        int exp_v;
        longint s;
        logic signed [IN_W-1:0]  r;
        logic signed [ACC_W-1:0] b;
        int bias_v;

        tbl[0] = '{1'b0, 27, 0,  0, 27};
        tbl[1] = '{1'b0, 27, 1,  0, -131085};
        tbl[2] = '{1'b1,  5, 2,  0, 15};
        tbl[3] = '{1'b1,  5, 3,  0, -5};
        tbl[4] = '{1'b0, 27, 4,  0, 54};
        tbl[5] = '{1'b0, 27, 5,  0, 3538917};
        tbl[6] = '{1'b0, 27, 6,  0, -3538944};
        tbl[7] = '{1'b1,  5, 5,  0, 655355};
        tbl[8] = '{1'b0, 27, 0, -5, 27};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        bias_in = '0; sel5 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready_m), 1);
        check("rst_out_valid", int'(out_valid_m), 0);
        check("rst_busy", int'(busy_m), 0);
        check("rst_out_data", int'(out_data_m), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven directed vectors.
        foreach (tbl[k]) begin
            for (int i = 0; i < 27; i++) ops[i] = op_of(tbl[k].pat, i);
            exp_v = tbl[k].exp_sum + (BIAS_ON ? tbl[k].bias : 0);
            run_vector($sformatf("tbl%0d", k), tbl[k].s5, tbl[k].n, ops,
                       tbl[k].bias, exp_v);
        end

        // Result held while the consumer stalls; input ignored in DONE.
        sel5 = 1'b0; bias_in = '0; out_ready = 1'b0;
        for (int i = 0; i < 27; i++) drive_beat(3);
        begin
            int lat = 0;
            while (!out_valid_m && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            check("stall_latency", lat, 13);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_data = IN_W'(7);
            check("stall_out_valid", int'(out_valid_m), 1);
            check("stall_out_data", int'(out_data_m), 81);
            check("stall_in_ready", int'(in_ready_m), 0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stall_pre_hs_in_ready", int'(in_ready_m), 0);
        @(negedge clk);
        check("stall_post_hs_valid", int'(out_valid_m), 0);
        check("stall_post_hs_in_ready", int'(in_ready_m), 1);
        for (int i = 0; i < 27; i++) ops[i] = 1;
        run_vector("after_stall", 1'b0, 27, ops, 0, 27);

        // Reset in the middle of REDUCE (cycle 5).
        sel5 = 1'b0;
        for (int i = 0; i < 27; i++) drive_beat(int'($urandom_range(0, 5000)) - 2500);
        repeat (4) @(negedge clk);
        check("mid_reduce_busy", int'(busy_m), 1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", int'(in_ready_m), 1);
        check("abort_out_valid", int'(out_valid_m), 0);
        check("abort_busy", int'(busy_m), 0);
        check("abort_out_data", int'(out_data_m), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 27; i++) ops[i] = 2;
        run_vector("post_abort", 1'b0, 27, ops, 0, 54);

        // Reset in the middle of LOAD.
        for (int i = 0; i < 10; i++) drive_beat(1000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vector("post_load_abort", 1'b0, 27, ops, 0, 54);

        // Randomized vectors against the additive model.
        for (int k = 0; k < 12; k++) begin
            bit s5;
            int n;
            s5 = k[0];
            n  = s5 ? 5 : 27;
            s  = 0;
            for (int i = 0; i < 27; i++) begin
                r      = IN_W'($urandom);
                ops[i] = int'(r);
                if (i < n) s += ops[i];
            end
            b      = ACC_W'($urandom);
            bias_v = BIAS_ON ? int'(b) : 0;
            run_vector($sformatf("rand%0d", k), s5, n, ops, bias_v,
                       trunc_acc(s + bias_v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
